// File: rtl/spi_flash_arb_pkg.sv
// Shared types for the quad-SPI flash arbiter: state encoding and the
// bundle of pin signals a master presents to the flash.
package spi_flash_arb_pkg;

  localparam int NUM_LANES = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWN0  = 2'd1,
    ST_OWN1  = 2'd2,
    ST_GUARD = 2'd3
  } arb_state_e;

  typedef struct packed {
    logic                 sclk;
    logic                 cs_n;
    logic [NUM_LANES-1:0] qdo;
    logic [NUM_LANES-1:0] oe;
  } spi_pins_t;

  // Bus parked: flash deselected, clock low, all io lanes tri-stated.
  localparam spi_pins_t PINS_IDLE = '{sclk: 1'b0, cs_n: 1'b1, qdo: '0, oe: '0};

endpackage

// File: rtl/spi_flash_arb.sv
// Two-master quad-SPI flash arbiter. Ownership changes only while cs_n is
// high, and every handoff is followed by a programmable cs_n-high guard.
module spi_flash_arb
  import spi_flash_arb_pkg::*;
#(
  parameter logic [3:0] CS_GUARD = 4'd3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 m0_req,
  input  logic                 m1_req,
  output logic                 m0_gnt,
  output logic                 m1_gnt,
  input  logic                 m0_sclk,
  input  logic                 m1_sclk,
  input  logic                 m0_cs_n,
  input  logic                 m1_cs_n,
  input  logic [NUM_LANES-1:0] m0_qdo,
  input  logic [NUM_LANES-1:0] m1_qdo,
  input  logic [NUM_LANES-1:0] m0_oe,
  input  logic [NUM_LANES-1:0] m1_oe,
  output logic [NUM_LANES-1:0] m0_qdi,
  output logic [NUM_LANES-1:0] m1_qdi,
  output logic                 sclk,
  output logic                 cs_n,
  output logic [NUM_LANES-1:0] qdo,
  output logic [NUM_LANES-1:0] oe,
  input  logic [NUM_LANES-1:0] qdi,
  output logic                 busy
);

  arb_state_e state_q, state_d;
  logic       last_q, last_d;   // 1 = m1 served last
  logic [3:0] cnt_q, cnt_d;

  spi_pins_t m0_pins, m1_pins, pins;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      last_q  <= 1'b1;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (m0_req && (!m1_req || last_q)) begin
          state_d = ST_OWN0;
          last_d  = 1'b0;
        end else if (m1_req) begin
          state_d = ST_OWN1;
          last_d  = 1'b1;
        end
      end
      ST_OWN0: begin
        // A dropped request is honoured only once cs_n is back high.
        if (!m0_req && m0_cs_n) begin
          state_d = (CS_GUARD != 4'd0) ? ST_GUARD : ST_IDLE;
          cnt_d   = CS_GUARD - 4'd1;
        end
      end
      ST_OWN1: begin
        if (!m1_req && m1_cs_n) begin
          state_d = (CS_GUARD != 4'd0) ? ST_GUARD : ST_IDLE;
          cnt_d   = CS_GUARD - 4'd1;
        end
      end
      ST_GUARD: begin
        if (cnt_q == 4'd0) state_d = ST_IDLE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign m0_pins = '{sclk: m0_sclk, cs_n: m0_cs_n, qdo: m0_qdo, oe: m0_oe};
  assign m1_pins = '{sclk: m1_sclk, cs_n: m1_cs_n, qdo: m1_qdo, oe: m1_oe};

  // Selected by the async-reset state register, so reset parks the pins at once.
  always_comb begin
    pins = PINS_IDLE;
    case (state_q)
      ST_IDLE:  pins = PINS_IDLE;
      ST_OWN0:  pins = m0_pins;
      ST_OWN1:  pins = m1_pins;
      ST_GUARD: pins = PINS_IDLE;
      default:  pins = PINS_IDLE;
    endcase
  end

  assign sclk   = pins.sclk;
  assign cs_n   = pins.cs_n;
  assign qdo    = pins.qdo;
  assign oe     = pins.oe;

  assign m0_qdi = qdi;
  assign m1_qdi = qdi;

  assign m0_gnt = (state_q == ST_OWN0);
  assign m1_gnt = (state_q == ST_OWN1);
  assign busy   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_spi_flash_arb.sv
// Bench for spi_flash_arb: a CS_GUARD=3 and a CS_GUARD=0 instance share all
// inputs and are compared against an owner/guard-count reference model.
module tb_spi_flash_arb;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       m0_req, m1_req, m0_sclk, m1_sclk, m0_cs_n, m1_cs_n;
  logic [3:0] m0_qdo, m1_qdo, m0_oe, m1_oe, qdi;

  logic [1:0] m0_gnt_o, m1_gnt_o, sclk_o, cs_n_o, busy_o;
  logic [3:0] qdo_o [2];
  logic [3:0] oe_o [2];
  logic [3:0] m0_qdi_o [2];
  logic [3:0] m1_qdi_o [2];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  spi_flash_arb #(.CS_GUARD(4'd3)) dut3 (
    .clk(clk), .rst_n(rst_n), .m0_req(m0_req), .m1_req(m1_req),
    .m0_gnt(m0_gnt_o[0]), .m1_gnt(m1_gnt_o[0]),
    .m0_sclk(m0_sclk), .m1_sclk(m1_sclk), .m0_cs_n(m0_cs_n), .m1_cs_n(m1_cs_n),
    .m0_qdo(m0_qdo), .m1_qdo(m1_qdo), .m0_oe(m0_oe), .m1_oe(m1_oe),
    .m0_qdi(m0_qdi_o[0]), .m1_qdi(m1_qdi_o[0]),
    .sclk(sclk_o[0]), .cs_n(cs_n_o[0]), .qdo(qdo_o[0]), .oe(oe_o[0]),
    .qdi(qdi), .busy(busy_o[0]));

  spi_flash_arb #(.CS_GUARD(4'd0)) dut0 (
    .clk(clk), .rst_n(rst_n), .m0_req(m0_req), .m1_req(m1_req),
    .m0_gnt(m0_gnt_o[1]), .m1_gnt(m1_gnt_o[1]),
    .m0_sclk(m0_sclk), .m1_sclk(m1_sclk), .m0_cs_n(m0_cs_n), .m1_cs_n(m1_cs_n),
    .m0_qdo(m0_qdo), .m1_qdo(m1_qdo), .m0_oe(m0_oe), .m1_oe(m1_oe),
    .m0_qdi(m0_qdi_o[1]), .m1_qdi(m1_qdi_o[1]),
    .sclk(sclk_o[1]), .cs_n(cs_n_o[1]), .qdo(qdo_o[1]), .oe(oe_o[1]),
    .qdi(qdi), .busy(busy_o[1]));

  // Reference model per instance: current owner (-1 = none), edges still to
  // sit out before arbitrating again, and who was served last.
  int   own  [2];
  int   gleft[2];
  int   lst  [2];

  function automatic int guard_of(int d);
    return (d == 0) ? 3 : 0;
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    int o, g, l;
    logic [1:0] req, csn;
    if (!rst_n) begin
      for (int d = 0; d < 2; d++) begin
        own[d] <= -1; gleft[d] <= 0; lst[d] <= 1;
      end
    end else begin
      req = {m1_req, m0_req};
      csn = {m1_cs_n, m0_cs_n};
      for (int d = 0; d < 2; d++) begin
        o = own[d]; g = gleft[d]; l = lst[d];
        if (o >= 0) begin
          if (!req[o] && csn[o]) begin o = -1; g = guard_of(d); end
        end else if (g > 0) begin
          g = g - 1;
        end else if (req[0] && req[1]) begin
          o = 1 - l; l = o;
        end else if (req[0]) begin
          o = 0; l = 0;
        end else if (req[1]) begin
          o = 1; l = 1;
        end
        own[d] <= o; gleft[d] <= g; lst[d] <= l;
      end
    end
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    for (int d = 0; d < 2; d++) begin
      int o;
      logic es, ec;
      logic [3:0] eq, eo;
      o = own[d];
      es = 1'b0; ec = 1'b1; eq = 4'h0; eo = 4'h0;
      if (o == 0)      begin es = m0_sclk; ec = m0_cs_n; eq = m0_qdo; eo = m0_oe; end
      else if (o == 1) begin es = m1_sclk; ec = m1_cs_n; eq = m1_qdo; eo = m1_oe; end
      chk($sformatf("d%0d m0_gnt", d), 8'(m0_gnt_o[d]), 8'(o == 0));
      chk($sformatf("d%0d m1_gnt", d), 8'(m1_gnt_o[d]), 8'(o == 1));
      chk($sformatf("d%0d busy", d), 8'(busy_o[d]), 8'((o >= 0) || (gleft[d] > 0)));
      chk($sformatf("d%0d sclk", d), 8'(sclk_o[d]), 8'(es));
      chk($sformatf("d%0d cs_n", d), 8'(cs_n_o[d]), 8'(ec));
      chk($sformatf("d%0d qdo", d), 8'(qdo_o[d]), 8'(eq));
      chk($sformatf("d%0d oe", d), 8'(oe_o[d]), 8'(eo));
      chk($sformatf("d%0d m0_qdi", d), 8'(m0_qdi_o[d]), 8'(qdi));
      chk($sformatf("d%0d m1_qdi", d), 8'(m1_qdi_o[d]), 8'(qdi));
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic m1_noise();
    m1_sclk = 1'($urandom); m1_qdo = 4'($urandom); m1_oe = 4'($urandom);
    m1_cs_n = 1'($urandom);
  endtask

  task automatic idle_inputs();
    m0_req = 0; m1_req = 0; m0_sclk = 0; m1_sclk = 0; m0_cs_n = 1; m1_cs_n = 1;
    m0_qdo = 0; m1_qdo = 0; m0_oe = 0; m1_oe = 0; qdi = 4'h9;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    #1;
    check_all();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin : stim
    int n3, n0;
    rst_n = 1'b1;
    idle_inputs();
    #2;
    do_reset();
    chk("reset cs_n", 8'(cs_n_o[0]), 8'd1);
    chk("reset busy", 8'(busy_o[0]), 8'd0);

    // single request: grant after one edge, pins follow m0, m1 noise ignored
    m0_req = 1;
    step();
    chk("m0 grant latency", 8'(m0_gnt_o[0]), 8'd1);
    m0_cs_n = 0; m0_sclk = 1; m0_qdo = 4'h5; m0_oe = 4'hF;
    for (int i = 0; i < 4; i++) begin
      m1_noise(); m0_qdo = 4'($urandom);
      #1; check_all();
      chk("pins track m0 qdo", 8'(qdo_o[0]), 8'(m0_qdo));
      step();
    end

    // req drop with cs_n low must not release
    m0_req = 0;
    for (int i = 0; i < 10; i++) begin
      m1_noise(); m0_sclk = ~m0_sclk;
      step();
      chk("hold gnt while cs_n low", 8'(m0_gnt_o[0]), 8'd1);
    end
    m0_cs_n = 1; m1_cs_n = 1; m1_req = 0;
    step();
    chk("release on cs_n high", 8'(m0_gnt_o[0]), 8'd0);
    chk("guard cs_n", 8'(cs_n_o[0]), 8'd1);
    chk("guard oe", 8'(oe_o[0]), 8'd0);
    chk("guard busy", 8'(busy_o[0]), 8'd1);
    repeat (4) begin m1_noise(); m1_cs_n = 1; step(); end

    // simultaneous requests after reset: m0 first, then m1 after the guard
    do_reset();
    m0_req = 1; m1_req = 1;
    step();
    chk("tie grants m0", 8'(m0_gnt_o[0]), 8'd1);
    chk("tie m1 waits", 8'(m1_gnt_o[0]), 8'd0);
    m0_req = 0;
    step();
    n3 = 0; n0 = 0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (n3 == 0 && m1_gnt_o[0]) n3 = i;
      if (n0 == 0 && m1_gnt_o[1]) n0 = i;
    end
    chk("handoff latency guard3", 8'(n3), 8'd4);
    chk("handoff latency guard0", 8'(n0), 8'd1);

    // async reset in the middle of an m1 transaction
    m1_cs_n = 0; m1_oe = 4'hF; m1_qdo = 4'hA; m1_sclk = 1;
    #1; check_all();
    chk("m1 drives cs_n", 8'(cs_n_o[0]), 8'd0);
    #1; rst_n = 1'b0;
    #1; check_all();
    chk("async rst cs_n", 8'(cs_n_o[0]), 8'd1);
    chk("async rst oe", 8'(oe_o[0]), 8'd0);
    chk("async rst gnt", 8'(m1_gnt_o[0]), 8'd0);
    do_reset();
    m0_req = 1; m1_req = 1;
    step();
    chk("post-reset tie m0", 8'(m0_gnt_o[0]), 8'd1);

    // randomized traffic with occasional mid-cycle resets
    for (int i = 0; i < 600; i++) begin
      m0_req  = ($urandom_range(0, 3) != 0);
      m1_req  = ($urandom_range(0, 3) != 0);
      m0_cs_n = ($urandom_range(0, 2) != 0);
      m1_cs_n = ($urandom_range(0, 2) != 0);
      m0_sclk = 1'($urandom); m1_sclk = 1'($urandom);
      m0_qdo = 4'($urandom); m1_qdo = 4'($urandom);
      m0_oe  = 4'($urandom); m1_oe  = 4'($urandom);
      qdi    = 4'($urandom);
      #1; check_all();
      if ($urandom_range(0, 49) == 0) begin
        #1; rst_n = 1'b0;
        #1; check_all();
        #1; rst_n = 1'b1;
      end
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
